dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single 256-bit Data_Memory port between two cache controllers: port 0 (instruction cache refill) and port 1 (data cache refill/write-back).
- Sits between the cache controllers' `mem_*` interfaces and Data_Memory.
- Grants one transaction at a time with round-robin priority and latches the winner's command.
- Returns the memory acknowledge only to the granted port and enforces a one-cycle bus gap between transactions.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 256, cache line width.
- TIMEOUT, 1023, cycles in BUSY without ack before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- m0_enable_i  in  1  port 0 request (level; held until its ack).
- m0_write_i  in  1  port 0 write (1) / read (0).
- m0_addr_i  in  ADDR_W  port 0 line address.
- m0_data_i  in  DATA_W  port 0 write data.
- m0_ack_o  out  1  port 0 transaction done (1-cycle pulse).
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i  in  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0.
- m1_ack_o  out  1  port 1 transaction done (1-cycle pulse).
- m_data_o  out  DATA_W  read data to both ports; equals mem_data_i combinationally.
- mem_data_i  in  DATA_W  Data_Memory read data.
- mem_ack_i  in  1  Data_Memory acknowledge.
- mem_enable_o  out  1  Data_Memory enable.
- mem_write_o  out  1  Data_Memory write.
- mem_addr_o  out  ADDR_W  Data_Memory address.
- mem_data_o  out  DATA_W  Data_Memory write data.
- gnt_o  out  2  one-hot current owner; 00 when no owner.
- timeout_o  out  1  sticky watchdog error flag.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset:
  - state=ARB; gnt_o=00; last_grant=1, so port 0 wins the first contention.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - Both acks 0; timeout_o=0; watchdog count=0.
  - Reset mid-BUSY aborts the transaction; no ack is forwarded.
- States: ARB, BUSY, GAP.
- ARB:
  - Sample m0_enable_i and m1_enable_i.
  - Neither asserted: stay in ARB.
  - One asserted: grant it.
  - Both asserted: grant the port not equal to last_grant.
  - On grant:
    - latch enable/write/addr/data of the winner into the command registers;
    - set gnt_o and last_grant;
    - clear the watchdog count;
    - go to BUSY.
- BUSY:
  - mem_enable_o=1; write/addr/data come from the latched registers.
  - Port inputs are ignored while BUSY, so a requester changing its inputs has no effect.
  - Latency: request seen in ARB at cycle t; mem_enable_o=1 from t+1.
  - If mem_ack_i=1:
    - pulse the granted port's ack_o in the same cycle (combinational, masked by gnt_o);
    - go to GAP.
  - Else if TIMEOUT≠0 and the watchdog count reaches TIMEOUT-1:
    - set timeout_o;
    - go to GAP with no ack forwarded.
  - Else increment the watchdog count.
- GAP:
  - mem_enable_o=0, mem_write_o=0, gnt_o=00.
  - Go to ARB unconditionally.
  - This masks a requester that keeps enable high for one cycle after its ack.
  - A requester that still holds enable in the following ARB cycle is a new request, e.g. the data cache's write-back followed by its refill read. That request is arbitrated normally; round-robin still applies.
- mem_ack_i outside BUSY is ignored; both acks stay 0.
- Acks are never asserted simultaneously; ack_o is never asserted for a port not in gnt_o.
- mem_addr_o and mem_data_o hold their last latched values outside BUSY; only mem_enable_o qualifies them.
- timeout_o clears only on rst_i.

Test Plan:
- Single read, port 0:
  - Stimulus: m0_enable_i=1, write=0, addr=0x0000_0120 at cycle 0; mem_ack_i pulsed at cycle 5.
  - Response: mem_enable_o=1 and mem_addr_o=0x120 at cycles 1-5; m0_ack_o=1 at cycle 5 only; mem_enable_o=0 at cycle 6; m1_ack_o stays 0.
- Contention:
  - Stimulus: both enables asserted at cycle 0 after reset; each ack 3 cycles after its BUSY starts.
  - Response: port 0 granted first (gnt_o=01), then port 1 (gnt_o=10); a third simultaneous request goes to port 0 again.
- Write-back then refill on port 1:
  - Stimulus: write=1, addr=0x2E0, data=all 0xA5; after the ack, the same cycle switches to write=0, addr=0x520.
  - Response: mem_write_o=1 with 0x2E0, then GAP, then a new BUSY with mem_write_o=0 and addr 0x520.
- Lingering enable:
  - Stimulus: port 1 keeps enable=1 exactly one cycle after m1_ack_o, then drops it.
  - Response: that cycle is GAP; no second memory transaction; state returns to ARB idle.
- Reset mid-transaction:
  - Stimulus: rst_i=1 during BUSY, then mem_ack_i=1 on the cycle after reset.
  - Response: mem_enable_o=0 and gnt_o=00 on the cycle after the reset edge; both acks stay 0.
- Timeout:
  - Stimulus: TIMEOUT=8, request issued, mem_ack_i never asserted.
  - Response: after 8 BUSY cycles, timeout_o=1 (sticky) and GAP; no ack; a pending request from the other port is granted afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one Data_Memory line port between the I-cache (port 0)
// and D-cache (port 1); one transaction at a time with a one-cycle bus gap.
module dmem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [1:0]        gnt_o,
    output logic              timeout_o
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ARB, BUSY, GAP} state_e;

    state_e            state_q;
    logic [1:0]        gnt_q;
    logic              last_grant_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              timeout_q;
    logic [WD_W-1:0]   wdog_q;

    logic pick_m1;
    logic req_any;
    logic busy_ack;

    // Port 1 wins when it is alone, or when both ask and port 0 was served last.
    always_comb begin
        req_any = m0_enable_i | m1_enable_i;
        pick_m1 = m1_enable_i & (~m0_enable_i | ~last_grant_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB;
            gnt_q        <= '0;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            timeout_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (req_any) begin
                        gnt_q        <= pick_m1 ? 2'b10 : 2'b01;
                        last_grant_q <= pick_m1;
                        mem_en_q     <= 1'b1;
                        mem_wr_q     <= pick_m1 ? m1_write_i : m0_write_i;
                        addr_q       <= pick_m1 ? m1_addr_i : m0_addr_i;
                        data_q       <= pick_m1 ? m1_data_i : m0_data_i;
                        wdog_q       <= '0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack_i || (TIMEOUT != 0 && wdog_q == WD_LAST)) begin
                        // An ack on the final watchdog cycle still counts as success.
                        if (!mem_ack_i) begin
                            timeout_q <= 1'b1;
                        end
                        gnt_q    <= '0;
                        mem_en_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                GAP: begin
                    state_q <= ARB;
                end
                default: begin
                    state_q <= ARB;
                end
            endcase
        end
    end

    assign busy_ack     = (state_q == BUSY) & mem_ack_i & ~rst_i;
    assign m0_ack_o     = busy_ack & gnt_q[0];
    assign m1_ack_o     = busy_ack & gnt_q[1];
    assign m_data_o     = mem_data_i;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign gnt_o        = gnt_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-port request queues, transaction-level expectations
// (round-robin winner, BUSY length, ack cycle, watchdog) and randomized traffic.
module tb_dmem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 256;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m0_ack_o;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i;
    logic          m1_enable_i, m1_write_i, m1_ack_o;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic [DW-1:0] m_data_o, mem_data_i, mem_data_o;
    logic          mem_ack_i, mem_enable_o, mem_write_o, timeout_o;
    logic [AW-1:0] mem_addr_o;
    logic [1:0]    gnt_o;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o),
        .m_data_o(m_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    // dly: BUSY cycle on which memory acks (beyond TMO means never); rst_at: BUSY cycle to reset on.
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int unsigned   dly;
        int unsigned   rst_at;
    } req_t;

    req_t          q0[$], q1[$];
    int            checks = 0;
    int            errors = 0;
    int            last_w;
    logic          exp_tmo;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            ack_after_rst = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] v;
        for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic req_t mk_req(input logic wr, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] data, input int unsigned dly,
                                    input int unsigned rst_at);
        req_t r;
        r.wr = wr; r.addr = addr; r.data = data; r.dly = dly; r.rst_at = rst_at;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk_req(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFE0, rnd_line(),
                      $urandom_range(1, 10), 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_w   = 1;
        exp_tmo  = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic present();
        if (q0.size() > 0) begin
            m0_enable_i = 1'b1; m0_write_i = q0[0].wr; m0_addr_i = q0[0].addr; m0_data_i = q0[0].data;
        end else begin
            m0_enable_i = 1'b0; m0_write_i = 1'($urandom_range(0, 1));
            m0_addr_i = $urandom(); m0_data_i = rnd_line();
        end
        if (q1.size() > 0) begin
            m1_enable_i = 1'b1; m1_write_i = q1[0].wr; m1_addr_i = q1[0].addr; m1_data_i = q1[0].data;
        end else begin
            m1_enable_i = 1'b0; m1_write_i = 1'($urandom_range(0, 1));
            m1_addr_i = $urandom(); m1_data_i = rnd_line();
        end
    endtask

    task automatic scramble(input int w);
        if (w == 0) begin
            m0_write_i = 1'($urandom_range(0, 1)); m0_addr_i = $urandom(); m0_data_i = rnd_line();
        end else begin
            m1_write_i = 1'($urandom_range(0, 1)); m1_addr_i = $urandom(); m1_data_i = rnd_line();
        end
    endtask

    task automatic check_idle(input string ph);
        check({ph, "_en"},    mem_enable_o, 1'b0);
        check({ph, "_wr"},    mem_write_o, 1'b0);
        check({ph, "_gnt"},   gnt_o, 2'b00);
        check({ph, "_ack0"},  m0_ack_o, 1'b0);
        check({ph, "_ack1"},  m1_ack_o, 1'b0);
        check({ph, "_addr"},  mem_addr_o, exp_addr);
        check({ph, "_data"},  mem_data_o, exp_data);
        check({ph, "_tmo"},   timeout_o, exp_tmo);
        check({ph, "_rdata"}, m_data_o, mem_data_i);
    endtask

    // One ARB cycle; when someone is requesting, the whole BUSY/GAP transaction follows.
    task automatic step_arb();
        int   w;
        bit   acked;
        req_t r;
        mem_ack_i     = ack_after_rst ? 1'b1 : 1'($urandom_range(0, 1));
        ack_after_rst = 1'b0;
        mem_data_i    = rnd_line();
        present();
        #1;
        check_idle("arb");
        if (q0.size() == 0 && q1.size() == 0) begin
            tick();
            return;
        end
        if (q0.size() > 0 && q1.size() > 0) w = (last_w == 0) ? 1 : 0;
        else w = (q0.size() > 0) ? 0 : 1;
        r = (w == 0) ? q0[0] : q1[0];
        last_w = w; exp_addr = r.addr; exp_data = r.data;
        tick();
        acked = 1'b0;
        for (int k = 1; k <= int'(TMO); k++) begin
            mem_ack_i  = (k == int'(r.dly));
            mem_data_i = rnd_line();
            if (k == int'(r.rst_at)) begin
                rst_i = 1'b1; mem_ack_i = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) scramble(w);
            #1;
            check("busy_en",   mem_enable_o, 1'b1);
            check("busy_wr",   mem_write_o, r.wr);
            check("busy_addr", mem_addr_o, r.addr);
            check("busy_data", mem_data_o, r.data);
            check("busy_gnt",  gnt_o, (w == 0) ? 2'b01 : 2'b10);
            check("ack_win",   (w == 0) ? m0_ack_o : m1_ack_o, mem_ack_i);
            check("ack_lose",  (w == 0) ? m1_ack_o : m0_ack_o, 1'b0);
            check("busy_tmo",  timeout_o, exp_tmo);
            check("busy_rdata", m_data_o, mem_data_i);
            if (rst_i) begin
                tick();
                rst_i = 1'b0;
                model_reset();
                if (w == 0) q0[0].rst_at = 0; else q1[0].rst_at = 0;
                ack_after_rst = 1'b1;
                return;
            end
            if (k == int'(r.dly)) begin
                acked = 1'b1;
                if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                // Back-to-back requests switch right away; otherwise enable lingers into GAP.
                if ((w == 0 && q0.size() > 0) || (w == 1 && q1.size() > 0)) present();
                else if (w == 0) m0_enable_i = 1'b1;
                else m1_enable_i = 1'b1;
                break;
            end
            if (k < int'(TMO)) tick();
        end
        if (!acked) begin
            exp_tmo = 1'b1;
            if (w == 0) q0[0].dly = $urandom_range(1, TMO - 1);
            else q1[0].dly = $urandom_range(1, TMO - 1);
        end
        tick();
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = rnd_line();
        #1;
        check_idle("gap");
        tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (q0.size() > 0 || q1.size() > 0); n++) step_arb();
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);
        step_arb();
    endtask

    initial begin
        rst_i = 1'b1; mem_ack_i = 1'b0; mem_data_i = '0;
        present();
        tick();
        tick();
        model_reset();
        check_idle("reset");
        rst_i = 1'b0;

        q0.push_back(mk_req(1'b0, 32'h0000_0120, rnd_line(), 5, 0));
        drain();

        q0.push_back(mk_req(1'b0, 32'h0000_1000, rnd_line(), 3, 0));
        q0.push_back(mk_req(1'b1, 32'h0000_3000, rnd_line(), 3, 0));
        q1.push_back(mk_req(1'b0, 32'h0000_2000, rnd_line(), 3, 0));
        q1.push_back(mk_req(1'b1, 32'h0000_4000, rnd_line(), 3, 0));
        drain();

        q1.push_back(mk_req(1'b1, 32'h0000_02E0, {32{8'hA5}}, 4, 0));
        q1.push_back(mk_req(1'b0, 32'h0000_0520, rnd_line(), 4, 0));
        drain();

        q0.push_back(mk_req(1'b0, 32'h0000_0640, rnd_line(), 20, 0));
        q1.push_back(mk_req(1'b0, 32'h0000_0660, rnd_line(), 2, 0));
        drain();

        q0.push_back(mk_req(1'b0, 32'h0000_0780, rnd_line(), 6, 3));
        drain();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) q0.push_back(rnd_req());
            if ($urandom_range(0, 3) == 0) q1.push_back(rnd_req());
            step_arb();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

endmodule
